// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-segment driver.
// Scans NUM_DIGITS hex digits one slot at a time. New values are swapped in
// only at frame boundaries so a frame never mixes two values. Leading-zero
// blanking, per-digit blink and output polarity are applied on the way out.
module seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

    logic [CW-1:0]                 cnt;
    logic [IW-1:0]                 idx;
    logic [NUM_DIGITS-1:0][3:0]    disp, pend;
    logic [NUM_DIGITS-1:0]         disp_dp, pend_dp;
    logic                          pend_valid;
    logic [BW-1:0]                 blink_cnt;
    logic                          blink_phase;
    logic [6:0]                    seg_r, seg_nxt;
    logic                          dp_r, dp_nxt;
    logic [NUM_DIGITS-1:0]         an_r, an_nxt;
    logic                          boundary;
    logic                          lit;
    logic                          zero_above;
    logic [NUM_DIGITS-1:0]         lz_blank;

    // Hex digit to {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'h0: decode = 7'b0111111;
            4'h1: decode = 7'b0000110;
            4'h2: decode = 7'b1011011;
            4'h3: decode = 7'b1001111;
            4'h4: decode = 7'b1100110;
            4'h5: decode = 7'b1101101;
            4'h6: decode = 7'b1111101;
            4'h7: decode = 7'b0000111;
            4'h8: decode = 7'b1111111;
            4'h9: decode = 7'b1101111;
            4'hA: decode = 7'b1110111;
            4'hB: decode = 7'b1111100;
            4'hC: decode = 7'b0111001;
            4'hD: decode = 7'b1011110;
            4'hE: decode = 7'b1111001;
            default: decode = 7'b1110001;
        endcase
    endfunction

    // Frame boundary, blanking decisions and next output values for the current slot.
    always_comb begin
        boundary   = (cnt == CNT_LAST) && (idx == IDX_LAST);
        lz_blank   = '0;
        zero_above = 1'b1;
        // Walk down from the top digit; a digit is blanked while every digit
        // from the top down to it is zero. Digit 0 always shows.
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above  = zero_above && (disp[k] == 4'h0);
            lz_blank[k] = zero_above;
        end
        lit     = !(blank_lz && lz_blank[idx]) && !(blink_phase && blink_mask[idx]);
        seg_nxt = lit ? decode(disp[idx]) : 7'd0;
        dp_nxt  = lit && disp_dp[idx];
        an_nxt  = '0;
        an_nxt[idx] = lit;
    end

    // Scan counter, digit index, double-buffered value load and blink timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            disp        <= '0;
            disp_dp     <= '0;
            pend        <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (boundary) begin
                // A load landing on the boundary bypasses the pending buffer.
                if (load) begin
                    disp    <= value;
                    disp_dp <= dp_in;
                end else if (pend_valid) begin
                    disp    <= pend;
                    disp_dp <= pend_dp;
                end
                pend_valid <= 1'b0;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end else if (load) begin
                pend       <= value;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end
        end
    end

    // Output registers; a single register keeps an strictly one-hot or zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_r <= '0;
            dp_r  <= 1'b0;
            an_r  <= '0;
        end else begin
            seg_r <= seg_nxt;
            dp_r  <= dp_nxt;
            an_r  <= an_nxt;
        end
    end

    assign seg = seg_r ^ {7{SEG_INV}};
    assign dp  = dp_r ^ SEG_INV;
    assign an  = an_r ^ {NUM_DIGITS{AN_INV}};
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
// A second instance with both polarities inverted shares all inputs and is
// expected to show the bitwise complement of the active-high instance.
module tb_seg_scan_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic [6:0]  seg, seg_i;
    logic        dp, dp_i, frame_done, fd_i;
    logic [3:0]  an, an_i;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2),
                      .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
        .blank_lz(blank_lz), .blink_mask(blink_mask), .seg(seg), .dp(dp),
        .an(an), .frame_done(frame_done));

    seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2),
                      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
        .blank_lz(blank_lz), .blink_mask(blink_mask), .seg(seg_i), .dp(dp_i),
        .an(an_i), .frame_done(fd_i));

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dpv;
        logic            blz;
        logic [3:0]      lit;
        logic [3:0][6:0] segs;   // segs[s] = pattern for slot s when lit
    } vec_t;

    vec_t vecs[9];

    task automatic check_slot(input string nm, input int s, input logic l,
                              input logic [6:0] es, input logic ed);
        logic [3:0]  ea;
        logic [11:0] exp_v, act, act_i;
        ea    = l ? (4'b0001 << s) : 4'b0000;
        exp_v = {ea, (l ? es : 7'd0), (l & ed)};
        act   = {an, seg, dp};
        act_i = {an_i, seg_i, dp_i};
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s slot%0d an/seg/dp got %b want %b", nm, s, act, exp_v);
        end
        checks++;
        if (act_i !== ~exp_v) begin
            failures++;
            $display("FAIL %s slot%0d inverted an/seg/dp got %b want %b", nm, s, act_i, ~exp_v);
        end
    endtask

    task automatic check_fd(input string nm, input logic e);
        checks++;
        if (frame_done !== e || fd_i !== e) begin
            failures++;
            $display("FAIL %s frame_done got %b/%b want %b", nm, frame_done, fd_i, e);
        end
    endtask

    // Returns at the negedge right after a boundary edge (frame_done high).
    task automatic wait_frame(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 64);
        if (frame_done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s frame_done timeout got %b want 1", nm, frame_done);
        end
    endtask

    // Called just after a boundary edge: checks each slot of the following frame.
    task automatic check_frame(input string nm, input logic [3:0] l,
                               input logic [3:0][6:0] segs, input logic [3:0] dps);
        for (int s = 0; s < 4; s++) begin
            repeat ((s == 0) ? 1 : 4) @(negedge clk);
            check_slot(nm, s, l[s], segs[s], dps[s]);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h0123, 4'h0, 1'b0, 4'hF, {7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111}};
        vecs[1] = '{16'h4567, 4'h0, 1'b0, 4'hF, {7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111}};
        vecs[2] = '{16'h89AB, 4'h0, 1'b0, 4'hF, {7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100}};
        vecs[3] = '{16'hCDEF, 4'h5, 1'b0, 4'hF, {7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001}};
        vecs[4] = '{16'h0070, 4'h0, 1'b1, 4'h3, {7'b0111111, 7'b0111111, 7'b0000111, 7'b0111111}};
        vecs[5] = '{16'h0000, 4'hF, 1'b1, 4'h1, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};
        vecs[6] = '{16'h0000, 4'h0, 1'b0, 4'hF, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};
        vecs[7] = '{16'h0070, 4'h0, 1'b0, 4'hF, {7'b0111111, 7'b0111111, 7'b0000111, 7'b0111111}};
        vecs[8] = '{16'h0800, 4'h4, 1'b1, 4'h7, {7'b0111111, 7'b1111111, 7'b0111111, 7'b0111111}};

        // Reset held for three edges: everything off.
        repeat (3) @(negedge clk);
        check_slot("reset", 0, 1'b0, 7'd0, 1'b0);
        check_fd("reset", 1'b0);
        rst_n = 1'b1;
        // Idle scan of an all-zero display: 4 cycles per slot, frame pulse at t=15.
        for (int t = 0; t <= 16; t++) begin
            @(negedge clk);
            if (t % 4 == 0) check_slot("idle_scan", (t / 4) % 4, 1'b1, 7'b0111111, 1'b0);
            check_fd("idle_fd", (t == 15));
        end

        // Table: load mid-frame, check the whole next frame.
        foreach (vecs[i]) begin
            wait_frame("vec_sync");
            blank_lz = vecs[i].blz;
            pulse_load(vecs[i].val, vecs[i].dpv);
            wait_frame("vec");
            check_frame($sformatf("vec%0d", i), vecs[i].lit, vecs[i].segs, vecs[i].dpv);
        end

        // Tear-free: a load during slot 1 must not disturb slots 2 and 3.
        blank_lz = 1'b0;
        wait_frame("tear_sync");
        pulse_load(16'hAAAA, 4'h0);
        wait_frame("tear_a");
        @(negedge clk);
        check_slot("tear_old", 0, 1'b1, 7'b1110111, 1'b0);
        repeat (4) @(negedge clk);
        check_slot("tear_old", 1, 1'b1, 7'b1110111, 1'b0);
        pulse_load(16'h1234, 4'h0);
        repeat (3) @(negedge clk);
        check_slot("tear_old", 2, 1'b1, 7'b1110111, 1'b0);
        repeat (4) @(negedge clk);
        check_slot("tear_old", 3, 1'b1, 7'b1110111, 1'b0);
        wait_frame("tear_new");
        check_frame("tear_new", 4'hF, {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}, 4'h0);

        // Load exactly on the boundary cycle shows in the very next slot 0.
        wait_frame("bnd_sync");
        repeat (15) @(negedge clk);
        pulse_load(16'h00C5, 4'h1);
        check_fd("bnd_fd", 1'b1);
        @(negedge clk);
        check_slot("bnd_load", 0, 1'b1, 7'b1101101, 1'b1);
        repeat (4) @(negedge clk);
        check_slot("bnd_load", 1, 1'b1, 7'b0111001, 1'b0);

        // Reset at index 2 with a load pending: outputs off, pending lost.
        wait_frame("rst_sync");
        pulse_load(16'h9999, 4'hF);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_slot("mid_reset", 0, 1'b0, 7'd0, 1'b0);
        check_fd("mid_reset", 1'b0);
        rst_n = 1'b1;
        check_frame("post_rst_f0", 4'hF, {4{7'b0111111}}, 4'h0);
        wait_frame("post_rst");
        check_frame("post_rst_f1", 4'hF, {4{7'b0111111}}, 4'h0);

        // Blink: slot 1 dark in frames 2-3 with BLINK_FRAMES=2.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        blink_mask = 4'b0010;
        pulse_load(16'h1111, 4'h0);
        for (int f = 1; f <= 5; f++) begin
            wait_frame("blink");
            check_frame($sformatf("blink_f%0d", f), (f == 2 || f == 3) ? 4'b1101 : 4'b1111,
                        {4{7'b0000110}}, 4'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
